// File: rtl/sfx_pkg.sv
// Shared types and constants for the Breakout sound-effect sequencer.
package sfx_pkg;

  localparam int unsigned SFX_W         = 2;
  localparam int unsigned NOTE_W        = 4;
  localparam int unsigned IDX_W         = 2;
  localparam int unsigned NOTES_PER_SFX = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [SFX_W-1:0] SFX_NONE   = 2'd0;
  localparam logic [SFX_W-1:0] SFX_WALL   = 2'd1;
  localparam logic [SFX_W-1:0] SFX_PLATE  = 2'd2;
  localparam logic [SFX_W-1:0] SFX_GROUND = 2'd3;

  // Element [0] is the first note played.
  localparam logic [2:0][NOTE_W-1:0] NOTES_WALL   = {4'd5, 4'd6, 4'd7};
  localparam logic [2:0][NOTE_W-1:0] NOTES_PLATE  = {4'd2, 4'd6, 4'd3};
  localparam logic [2:0][NOTE_W-1:0] NOTES_GROUND = {4'd1, 4'd5, 4'd7};

  function automatic logic [NOTE_W-1:0] note_lookup(input logic [SFX_W-1:0] sfx,
                                                    input logic [IDX_W-1:0] idx);
    logic [NOTE_W-1:0] n;
    n = '0;
    if (idx < IDX_W'(NOTES_PER_SFX)) begin
      case (sfx)
        SFX_WALL:   n = NOTES_WALL[idx];
        SFX_PLATE:  n = NOTES_PLATE[idx];
        SFX_GROUND: n = NOTES_GROUND[idx];
        default:    n = '0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/sfx_arbiter.sv
// Pending-hit latches with fixed priority grant (ground > plate > wall).
module sfx_arbiter
  import sfx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_wall,
  input  logic             hit_plate,
  input  logic             hit_ground,
  input  logic             take,
  input  logic [SFX_W-1:0] take_id,
  input  logic [SFX_W-1:0] active_id,
  output logic             grant_valid,
  output logic [SFX_W-1:0] grant_id,
  output logic             higher_than
);

  // bit0 wall, bit1 plate, bit2 ground
  logic [2:0] pend_q, pend_d;
  logic [2:0] clr_mask;

  // New hits are OR-ed after the clear so a hit on the grant edge survives.
  always_comb begin
    clr_mask = '0;
    if (take) begin
      case (take_id)
        SFX_WALL:   clr_mask = 3'b001;
        SFX_PLATE:  clr_mask = 3'b010;
        SFX_GROUND: clr_mask = 3'b100;
        default:    clr_mask = 3'b000;
      endcase
    end
    pend_d = (pend_q & ~clr_mask) | {hit_ground, hit_plate, hit_wall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // The encoding doubles as priority, so "any higher pending" reduces to top > active.
  always_comb begin
    grant_valid = |pend_q;
    if (pend_q[2])      grant_id = SFX_GROUND;
    else if (pend_q[1]) grant_id = SFX_PLATE;
    else if (pend_q[0]) grant_id = SFX_WALL;
    else                grant_id = SFX_NONE;
    higher_than = (grant_id > active_id);
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Plays a three-note sequence per granted effect over valid/ready, with preemption at note end.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES = 12_500_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Hit_wall,
  input  logic              Hit_plate,
  input  logic              Hit_ground,
  input  logic              note_ready,
  output logic              note_valid,
  output logic [NOTE_W-1:0] note_code,
  output logic              busy,
  output logic [SFX_W-1:0]  active_sfx
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTES_PER_SFX - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SFX_W-1:0]   active_q, active_d;
  logic               valid_q, valid_d;
  logic [NOTE_W-1:0]  code_q, code_d;
  logic               busy_q, busy_d;

  logic               start;
  logic               grant_valid;
  logic [SFX_W-1:0]   grant_id;
  logic               higher_than;

  sfx_arbiter u_arbiter (
    .clk         (clk),
    .rst_n       (reset),
    .hit_wall    (Hit_wall),
    .hit_plate   (Hit_plate),
    .hit_ground  (Hit_ground),
    .take        (start),
    .take_id     (grant_id),
    .active_id   (active_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .higher_than (higher_than)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    valid_d  = valid_q;
    code_d   = code_q;
    start    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) start = 1'b1;
      end
      ISSUE: begin
        if (valid_q && note_ready) begin
          state_d = HOLD;
          valid_d = 1'b0;
          cnt_d   = CNT_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (higher_than) begin
          start = 1'b1;
        end else if (idx_q < IDX_LAST) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ISSUE;
          valid_d = 1'b1;
          code_d  = note_lookup(active_q, idx_q + IDX_W'(1));
        end else if (grant_valid) begin
          start = 1'b1;
        end else begin
          state_d  = IDLE;
          active_d = SFX_NONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared grant path for IDLE start, preemption and back-to-back effects.
    if (start) begin
      state_d  = ISSUE;
      idx_d    = '0;
      active_d = grant_id;
      valid_d  = 1'b1;
      code_d   = note_lookup(grant_id, '0);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      active_q <= SFX_NONE;
      valid_q  <= 1'b0;
      code_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
    end
  end

  assign note_valid = valid_q;
  assign note_code  = code_q;
  assign busy       = busy_q;
  assign active_sfx = active_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed and random bench for sfx_sequencer against a behavioural effect-playback model.
module tb_sfx_sequencer;

  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       Hit_wall, Hit_plate, Hit_ground, note_ready;
  logic       note_valid;
  logic [3:0] note_code;
  logic       busy;
  logic [1:0] active_sfx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_q[$];
  int acc_t[$];

  // Reference model: per-effect pending flags, current effect, note position, hold time left.
  int notes [4][3] = '{'{0, 0, 0}, '{7, 6, 5}, '{3, 6, 2}, '{7, 5, 1}};
  int m_pend[4];
  int m_active, m_idx, m_phase, m_left, m_code, m_valid;

  always #5 clk = ~clk;

  sfx_sequencer #(.NOTE_CYCLES(NC), .CNT_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .Hit_wall   (Hit_wall),
    .Hit_plate  (Hit_plate),
    .Hit_ground (Hit_ground),
    .note_ready (note_ready),
    .note_valid (note_valid),
    .note_code  (note_code),
    .busy       (busy),
    .active_sfx (active_sfx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < 4; s++) m_pend[s] = 0;
    m_active = 0; m_idx = 0; m_phase = 0; m_left = 0; m_code = 0; m_valid = 0;
  endtask

  function automatic int m_top();
    for (int s = 3; s >= 1; s--) if (m_pend[s] != 0) return s;
    return 0;
  endfunction

  task automatic m_start(input int s);
    m_pend[s] = 0;
    m_active  = s;
    m_idx     = 0;
    m_phase   = 1;
    m_valid   = 1;
    m_code    = notes[s][0];
  endtask

  // Phase 0 idle, 1 offering a note, 2 holding a note.
  task automatic m_step(input bit hw, input bit hp, input bit hg, input bit rdy);
    int t;
    t = m_top();
    if (m_phase == 0) begin
      if (t != 0) m_start(t);
    end else if (m_phase == 1) begin
      if (rdy) begin m_phase = 2; m_left = NC - 1; m_valid = 0; end
    end else begin
      if (m_left > 0) m_left--;
      else if (t > m_active) m_start(t);
      else if (m_idx < 2) begin
        m_idx++; m_phase = 1; m_valid = 1; m_code = notes[m_active][m_idx];
      end else if (t != 0) m_start(t);
      else begin m_phase = 0; m_active = 0; end
    end
    if (hw) m_pend[1] = 1;
    if (hp) m_pend[2] = 1;
    if (hg) m_pend[3] = 1;
  endtask

  // One clock: drive at negedge, record handshake, step model at posedge, compare at next negedge.
  task automatic cycle(input bit hw, input bit hp, input bit hg, input bit rdy);
    Hit_wall = hw; Hit_plate = hp; Hit_ground = hg; note_ready = rdy;
    if (note_valid === 1'b1 && rdy) begin
      acc_q.push_back(int'(note_code));
      acc_t.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    m_step(hw, hp, hg, rdy);
    @(negedge clk);
    Hit_wall = 1'b0; Hit_plate = 1'b0; Hit_ground = 1'b0;
    chk("note_valid", note_valid, m_valid);
    chk("note_code", note_code, m_code);
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
    chk("active_sfx", active_sfx, m_active);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (acc_q.size() >= n) break;
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("accept_timeout", (acc_q.size() >= n) ? 1 : 0, 1);
  endtask

  // exp lists notes first-played in the most significant nibble.
  task automatic check_seq(input string tag, input logic [63:0] exp, input int n);
    chk({tag, "_count"}, acc_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < acc_q.size()) chk(tag, acc_q[i], 32'(exp[4*(n-1-i) +: 4]));
  endtask

  task automatic check_gaps(input string tag);
    for (int i = 1; i < acc_t.size(); i++) chk(tag, acc_t[i] - acc_t[i-1], NC + 1);
  endtask

  task automatic new_scenario();
    acc_q.delete();
    acc_t.delete();
  endtask

  initial begin
    reset = 1'b0;
    Hit_wall = 1'b0; Hit_plate = 1'b0; Hit_ground = 1'b0; note_ready = 1'b1;
    m_reset();
    #1;
    chk("rst_valid", note_valid, 0);
    chk("rst_code", note_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active", active_sfx, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(3);

    // Single plate effect.
    new_scenario();
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    idle(25);
    check_seq("plate_seq", 64'h362, 3);
    check_gaps("plate_gap");
    chk("plate_done_busy", busy, 0);

    // All three hits at once: priority order, no idle gap between effects.
    new_scenario();
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    idle(55);
    check_seq("prio_seq", 64'h751362765, 9);
    check_gaps("prio_gap");

    // Ground preempts wall at the end of the first wall note.
    new_scenario();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    run_until(1, 20);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(40);
    check_seq("preempt_seq", 64'h7751, 4);

    // Repeated ground hits during ground playback coalesce into one replay.
    new_scenario();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    run_until(1, 20);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    run_until(2, 20);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(50);
    check_seq("coalesce_seq", 64'h751751, 6);

    // Stalled handshake keeps the offered note stable; wall hit meanwhile plays later.
    new_scenario();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle((i == 5), 1'b0, 1'b0, 1'b0);
      chk("stall_valid", note_valid, 1);
      chk("stall_code", note_code, 3);
    end
    idle(45);
    check_seq("stall_seq", 64'h362765, 6);

    // Asynchronous reset in the middle of the second plate note.
    new_scenario();
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    run_until(2, 30);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", note_valid, 0);
    chk("async_code", note_code, 0);
    chk("async_busy", busy, 0);
    chk("async_active", active_sfx, 0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    new_scenario();
    idle(15);
    chk("no_resume", acc_q.size(), 0);

    // Random hits and back-pressure against the model.
    for (int i = 0; i < 1200; i++)
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 23) == 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
